// File: rtl/dds_seq_pkg.sv
// Shared types and constants for the DDS frame path (reader, sequencer, serializer).
package dds_seq_pkg;

  // Full DDS register image, shared by the reader and the serializer.
  localparam int DDS_FRAME_W = 184;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    LOAD,
    SHIFT,
    UPDATE,
    SETTLE
  } state_t;

endpackage

// File: rtl/dds_frame_sequencer_if.sv
// Frame bus between the serial frame reader, the sequencer and the DDS serializer.
interface dds_frame_sequencer_if #(
  parameter int FRAME_W = dds_seq_pkg::DDS_FRAME_W
);
  logic [FRAME_W-1:0] frame_in;
  logic               frame_valid;
  logic [FRAME_W-1:0] ser_frame;
  logic               ser_start;
  logic               ser_done;
  logic               io_update;

  // master: the sequencer; slave: the reader/serializer side.
  modport master (
    input  frame_in, frame_valid, ser_done,
    output ser_frame, ser_start, io_update
  );
  modport slave (
    output frame_in, frame_valid, ser_done,
    input  ser_frame, ser_start, io_update
  );
endinterface

// File: rtl/dds_frame_sequencer_fifo.sv
// Frame FIFO: power-of-two depth, head is read combinationally so the
// sequencer can capture it in the same cycle it decides to start a frame.
module frame_fifo #(
  parameter int W     = 184,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/dds_frame_sequencer.sv
// Releases buffered DDS frames to the serializer one per trigger edge and
// follows each with a timed IO_UPDATE pulse plus a settle gap.
module dds_frame_sequencer
  import dds_seq_pkg::*;
#(
  parameter int FRAME_W  = DDS_FRAME_W,
  parameter int DEPTH    = 8,
  parameter int UPDATE_W = 4,
  parameter int SETTLE   = 2
) (
  input  logic                       ten_MHz_ext,
  input  logic                       reset,
  dds_frame_sequencer_if.master      bus,
  input  logic                       trigger_in,
  input  logic                       arm,
  output logic [$clog2(DEPTH):0]     frame_count,
  output logic                       busy,
  output logic                       overflow,
  output logic                       underrun,
  output logic                       missed_trig
);
  localparam int CNT_MAX = (UPDATE_W > SETTLE) ? UPDATE_W : SETTLE;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] UPD_LAST = CNT_W'(UPDATE_W - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         sync_q, sync_d;
  logic               trig_edge;
  logic               trig_pend_q, trig_pend_d;
  logic               overflow_q, overflow_d;
  logic               underrun_q, underrun_d;
  logic               missed_q, missed_d;
  logic               ser_start_q, ser_start_d;
  logic               io_update_q, io_update_d;
  logic               busy_q, busy_d;
  logic [FRAME_W-1:0] ser_frame_q, ser_frame_d;

  logic [FRAME_W-1:0]   head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 fifo_full, fifo_empty, pop;

  frame_fifo #(.W(FRAME_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (ten_MHz_ext),
    .rst   (reset),
    .push  (bus.frame_valid),
    .pop   (pop),
    .din   (bus.frame_in),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sync chain resets high so a trigger already high at release is not an edge.
  assign sync_d    = {sync_q[1:0], trigger_in};
  assign trig_edge = sync_q[1] & ~sync_q[2];
  assign pop       = (state_q == LOAD);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trig_pend_d = trig_pend_q;
    underrun_d  = underrun_q;
    missed_d    = missed_q;
    overflow_d  = overflow_q | (bus.frame_valid & fifo_full);

    case (state_q)
      IDLE: if (arm) state_d = ARMED;
      ARMED: begin
        if (!arm) begin
          state_d     = IDLE;
          trig_pend_d = 1'b0;
        end else if ((trig_edge || trig_pend_q) && !fifo_empty) begin
          state_d     = LOAD;
          trig_pend_d = 1'b0;
        end else if (trig_edge) begin
          underrun_d = 1'b1;
        end
      end
      LOAD: state_d = SHIFT;
      SHIFT: if (bus.ser_done) begin
        state_d = UPDATE;
        cnt_d   = '0;
      end
      UPDATE: begin
        if (cnt_q == UPD_LAST) begin
          cnt_d   = '0;
          // The state name is package-qualified: the SETTLE parameter shadows it.
          state_d = (SETTLE > 0) ? dds_seq_pkg::SETTLE : ARMED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      dds_seq_pkg::SETTLE: begin
        if (cnt_q == SET_LAST) state_d = ARMED;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (trig_edge && state_q != IDLE && state_q != ARMED) begin
      if (trig_pend_q) missed_d    = 1'b1;
      else             trig_pend_d = 1'b1;
    end

    // Outputs are registered from the next state so they align with it.
    ser_start_d = (state_d == LOAD);
    io_update_d = (state_d == UPDATE);
    busy_d      = (state_d != IDLE) && (state_d != ARMED);
    ser_frame_d = (state_d == LOAD && state_q == ARMED) ? head : ser_frame_q;
  end

  always_ff @(posedge ten_MHz_ext or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sync_q      <= 3'b111;
      trig_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
      missed_q    <= 1'b0;
      ser_start_q <= 1'b0;
      io_update_q <= 1'b0;
      busy_q      <= 1'b0;
      ser_frame_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      trig_pend_q <= trig_pend_d;
      overflow_q  <= overflow_d;
      underrun_q  <= underrun_d;
      missed_q    <= missed_d;
      ser_start_q <= ser_start_d;
      io_update_q <= io_update_d;
      busy_q      <= busy_d;
      ser_frame_q <= ser_frame_d;
    end
  end

  assign bus.ser_frame = ser_frame_q;
  assign bus.ser_start = ser_start_q;
  assign bus.io_update = io_update_q;
  assign frame_count   = fifo_count;
  assign busy          = busy_q;
  assign overflow      = overflow_q;
  assign underrun      = underrun_q;
  assign missed_trig   = missed_q;
endmodule

// File: tb/tb_dds_frame_sequencer.sv
// Bench for dds_frame_sequencer: timeline-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_dds_frame_sequencer;
  localparam int FRAME_W  = 184;
  localparam int DEPTH    = 8;
  localparam int UPDATE_W = 4;
  localparam int SETTLE   = 2;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int SER_LEN  = 184;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trigger_in = 1'b0;
  logic arm = 1'b0;
  logic [CW-1:0] frame_count;
  logic busy, overflow, underrun, missed_trig;

  dds_frame_sequencer_if #(.FRAME_W(FRAME_W)) bus ();

  dds_frame_sequencer #(
    .FRAME_W(FRAME_W), .DEPTH(DEPTH), .UPDATE_W(UPDATE_W), .SETTLE(SETTLE)
  ) dut (
    .ten_MHz_ext (clk),
    .reset       (rst),
    .bus         (bus),
    .trigger_in  (trigger_in),
    .arm         (arm),
    .frame_count (frame_count),
    .busy        (busy),
    .overflow    (overflow),
    .underrun    (underrun),
    .missed_trig (missed_trig)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [FRAME_W-1:0] act,
                       input logic [FRAME_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timeline view: a started frame is "pending start" for one cycle, then
  // shifting until ser_done, then post-done cycles 1..UPDATE_W are the pulse
  // and the next SETTLE cycles are the gap.
  logic [FRAME_W-1:0] mq[$];
  logic [FRAME_W-1:0] m_frame;
  bit m_armed, m_start, m_shift, m_pend, m_ovf, m_und, m_miss;
  int m_post;
  bit t1, t2, t3;

  task automatic model_clear();
    mq.delete();
    m_frame = '0;
    {m_armed, m_start, m_shift, m_pend, m_ovf, m_und, m_miss} = '0;
    m_post = 0;
    t1 = 1'b1; t2 = 1'b1; t3 = 1'b1;
  endtask

  task automatic model_step();
    bit edge_now, was_busy, was_full;
    edge_now = t2 & ~t3;   // trigger seen by the sequencer 3 edges after it rises
    t3 = t2; t2 = t1; t1 = trigger_in;
    was_busy = m_start || m_shift || (m_post != 0);
    was_full = (mq.size() == DEPTH);
    if (!was_busy) begin
      if (!m_armed) begin
        if (arm) m_armed = 1'b1;
      end else if (!arm) begin
        m_armed = 1'b0;
        m_pend  = 1'b0;
      end else if ((edge_now || m_pend) && mq.size() > 0) begin
        m_frame = mq[0];
        m_start = 1'b1;
        m_pend  = 1'b0;
      end else if (edge_now) begin
        m_und = 1'b1;
      end
    end else begin
      if (edge_now) begin
        if (m_pend) m_miss = 1'b1;
        else        m_pend = 1'b1;
      end
      if (m_start) begin
        m_start = 1'b0;
        m_shift = 1'b1;
        void'(mq.pop_front());
      end else if (m_shift) begin
        if (bus.ser_done) begin
          m_shift = 1'b0;
          m_post  = 1;
        end
      end else if (m_post == UPDATE_W + SETTLE) begin
        m_post = 0;
      end else begin
        m_post++;
      end
    end
    if (bus.frame_valid) begin
      if (was_full) m_ovf = 1'b1;
      else          mq.push_back(bus.frame_in);
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else     model_step();
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("ser_start",   bus.ser_start, m_start);
        check("io_update",   bus.io_update, (m_post >= 1 && m_post <= UPDATE_W));
        check("busy",        busy, (m_start || m_shift || m_post != 0));
        check("frame_count", frame_count, mq.size());
        check("ser_frame",   bus.ser_frame, m_frame);
        check("overflow",    overflow, m_ovf);
        check("underrun",    underrun, m_und);
        check("missed_trig", missed_trig, m_miss);
      end
    end
  end

  // Serializer stand-in: ser_done SER_LEN cycles after each ser_start.
  int ser_cnt = 0;
  initial begin
    bus.ser_done    = 1'b0;
    bus.frame_valid = 1'b0;
    bus.frame_in    = '0;
    forever begin
      @(negedge clk);
      bus.ser_done = 1'b0;
      if (rst) ser_cnt = 0;
      else begin
        if (ser_cnt > 0) begin
          ser_cnt--;
          if (ser_cnt == 0) bus.ser_done = 1'b1;
        end
        if (bus.ser_start) ser_cnt = SER_LEN;
      end
    end
  end

  // Monitor: start count, released frames, io_update gap and width.
  int starts = 0;
  logic [FRAME_W-1:0] got[$];
  int done_age = 1000, last_gap = -1, last_width = -1, cur_w = 0;
  bit prev_io = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.ser_start) begin
          starts++;
          got.push_back(bus.ser_frame);
        end
        done_age++;
        if (bus.ser_done) done_age = 0;
        if (bus.io_update && !prev_io) last_gap = done_age;
        if (bus.io_update) cur_w++;
        if (!bus.io_update && prev_io) begin
          last_width = cur_w;
          cur_w = 0;
        end
        prev_io = bus.io_update;
      end else begin
        prev_io = 1'b0;
        cur_w = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [FRAME_W-1:0] f);
    @(negedge clk);
    bus.frame_valid = 1'b1;
    bus.frame_in    = f;
    @(negedge clk);
    bus.frame_valid = 1'b0;
  endtask

  task automatic trig();
    @(negedge clk);
    trigger_in = 1'b1;
    wait_cyc(5);
    trigger_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
  endtask

  function automatic logic [FRAME_W-1:0] fill(input logic [7:0] b);
    logic [FRAME_W-1:0] f;
    for (int k = 0; k < FRAME_W / 8; k++) f[8*k +: 8] = b;
    return f;
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    logic [FRAME_W-1:0] pat [3];
    int s0;
    bit seen;
    pat[0] = fill(8'hA5);
    pat[1] = fill(8'h5A);
    pat[2] = '1;

    // Reset state
    wait_cyc(2);
    check("rst_ser_start", bus.ser_start, 1'b0);
    check("rst_io_update", bus.io_update, 1'b0);
    check("rst_ser_frame", bus.ser_frame, '0);
    check("rst_frame_count", frame_count, 0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    wait_cyc(2);

    // Three frames released in FIFO order, one per trigger
    for (int i = 0; i < 3; i++) push(pat[i]);
    arm = 1'b1;
    wait_cyc(3);
    got.delete();
    s0 = starts;
    for (int i = 0; i < 3; i++) begin
      check("t1_count_before", frame_count, 3 - i);
      trig();
      wait_cyc(500);
    end
    check("t1_count_end", frame_count, 0);
    check("t1_starts", starts - s0, 3);
    for (int i = 0; i < 3; i++) check("t1_frame", (got.size() > i) ? got[i] : '0, pat[i]);
    check("t1_io_gap", last_gap, 1);
    check("t1_io_width", last_width, 4);

    // Underrun on empty FIFO, then a normal sequence
    arm = 1'b0;
    do_reset();
    arm = 1'b1;
    wait_cyc(5);
    s0 = starts;
    trig();
    wait_cyc(50);
    check("t2_underrun", underrun, 1'b1);
    check("t2_no_start", starts - s0, 0);
    got.delete();
    push(pat[1]);
    trig();
    wait_cyc(300);
    check("t2_start", starts - s0, 1);
    check("t2_frame", (got.size() > 0) ? got[0] : '0, pat[1]);

    // Overflow: 9 pushes into 8 slots, 8 triggers release frames 1..8
    arm = 1'b0;
    do_reset();
    for (int i = 1; i <= 9; i++) push(fill(8'(i)));
    wait_cyc(1);
    check("t3_count_full", frame_count, 8);
    check("t3_overflow", overflow, 1'b1);
    arm = 1'b1;
    got.delete();
    s0 = starts;
    for (int i = 0; i < 8; i++) begin
      trig();
      wait_cyc(250);
    end
    check("t3_starts", starts - s0, 8);
    for (int i = 0; i < 8; i++) check("t3_frame", (got.size() > i) ? got[i] : '0, fill(8'(i + 1)));
    check("t3_count_end", frame_count, 0);

    // Two triggers during SHIFT: one pends, one is missed
    arm = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) push(pat[i]);
    arm = 1'b1;
    got.delete();
    s0 = starts;
    trig();
    wait_cyc(20);
    trig();
    wait_cyc(20);
    trig();
    wait_cyc(600);
    check("t4_starts", starts - s0, 2);
    check("t4_missed", missed_trig, 1'b1);
    check("t4_count", frame_count, 1);
    check("t4_frame2", (got.size() > 1) ? got[1] : '0, pat[1]);

    // Reset during io_update aborts everything
    arm = 1'b0;
    do_reset();
    arm = 1'b1;
    wait_cyc(3);
    trig();            // empty FIFO, sets underrun
    push(pat[0]);
    trig();
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = bus.io_update;
    end
    check("t5_io_seen", seen, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_io_async", bus.io_update, 1'b0);
    check("t5_count", frame_count, 0);
    check("t5_underrun", underrun, 1'b0);
    check("t5_busy", busy, 1'b0);
    wait_cyc(3);
    rst = 1'b0;
    s0 = starts;
    wait_cyc(1000);
    check("t5_quiet", starts - s0, 0);

    // Trigger high through reset release is not an edge
    arm = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    trigger_in = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    push(pat[2]);
    arm = 1'b1;
    s0 = starts;
    wait_cyc(50);
    check("t6_no_seq", starts - s0, 0);
    trigger_in = 1'b0;
    wait_cyc(10);
    trigger_in = 1'b1;
    @(negedge clk);
    check("t6_lat1", bus.ser_start, 1'b0);
    @(negedge clk);
    check("t6_lat2", bus.ser_start, 1'b0);
    @(negedge clk);
    check("t6_lat3", bus.ser_start, 1'b1);
    check("t6_frame", bus.ser_frame, pat[2]);
    wait_cyc(5);
    trigger_in = 1'b0;
    wait_cyc(250);
    check("t6_starts", starts - s0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
